// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed active-low seven-segment scan: filters
// ghosting, decodes each digit to hex and publishes a coherent 4-digit frame.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode,
    input  logic [6:0]  cathode,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  invalid,
    output logic        frame_valid,
    output logic        scan_error,
    output logic        display_off
);

    localparam int              IW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0]      STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [IW-1:0]   IDLE_MAX  = IW'(TIMEOUT_CYCLES);

    // {anode, cathode} through two sync stages, plus one more for change detect
    logic [10:0]    sync1_reg;
    logic [10:0]    sync2_reg;
    logic [10:0]    prev_reg;
    logic [7:0]     stab_reg;
    logic [15:0]    stage_digits_reg;
    logic [3:0]     stage_blank_reg;
    logic [3:0]     stage_invalid_reg;
    logic [3:0]     seen_reg;
    logic [IW-1:0]  idle_reg;
    logic [IW-1:0]  idle_next;

    logic [3:0]     an_low;
    logic           s_changed;
    logic           accept;
    logic           one_low;
    logic           multi_low;
    logic           capture;
    logic           publish;
    logic           timeout_hit;
    logic [5:0]     decoded;
    logic [3:0]     slot_hit;

    // Returns {blank, invalid, value}
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b010000;
        case (seg)
            7'h40: r = 6'h00;
            7'h79: r = 6'h01;
            7'h24: r = 6'h02;
            7'h30: r = 6'h03;
            7'h19: r = 6'h04;
            7'h12: r = 6'h05;
            7'h02: r = 6'h06;
            7'h78: r = 6'h07;
            7'h00: r = 6'h08;
            7'h10: r = 6'h09;
            7'h08: r = 6'h0A;
            7'h03: r = 6'h0B;
            7'h46: r = 6'h0C;
            7'h21: r = 6'h0D;
            7'h06: r = 6'h0E;
            7'h0E: r = 6'h0F;
            7'h7F: r = 6'b100000;
            default: r = 6'b010000;
        endcase
        return r;
    endfunction

    assign an_low      = ~sync2_reg[10:7];
    assign s_changed   = (sync2_reg != prev_reg);
    assign accept      = !s_changed && (stab_reg == STAB_LAST);
    assign one_low     = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
    assign multi_low   = (an_low != 4'd0) && !one_low;
    assign capture     = accept && one_low;
    assign publish     = (seen_reg == 4'hF);
    assign decoded     = decode_seg(sync2_reg[6:0]);

    assign idle_next   = capture ? '0 :
                         (idle_reg == IDLE_MAX) ? idle_reg : idle_reg + 1'b1;
    assign timeout_hit = (idle_next == IDLE_MAX);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_hit[gi] = capture && an_low[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg         <= '0;
            sync2_reg         <= '0;
            prev_reg          <= '0;
            stab_reg          <= '0;
            stage_digits_reg  <= '0;
            stage_blank_reg   <= '0;
            stage_invalid_reg <= '0;
            seen_reg          <= '0;
            idle_reg          <= '0;
            digits            <= '0;
            blank             <= '0;
            invalid           <= '0;
            frame_valid       <= 1'b0;
            scan_error        <= 1'b0;
            display_off       <= 1'b0;
        end else begin
            sync1_reg <= {anode, cathode};
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;

            if (s_changed)
                stab_reg <= 8'd1;
            else if (stab_reg != STAB_MAX)
                stab_reg <= stab_reg + 8'd1;

            idle_reg    <= idle_next;
            display_off <= timeout_hit;
            scan_error  <= accept && multi_low;
            frame_valid <= publish;

            if (publish) begin
                digits  <= stage_digits_reg;
                blank   <= stage_blank_reg;
                invalid <= stage_invalid_reg;
            end

            // Clear first so a same-cycle capture starts the next frame
            if (publish || timeout_hit)
                seen_reg <= slot_hit;
            else
                seen_reg <= seen_reg | slot_hit;

            for (int i = 0; i < 4; i++) begin
                if (slot_hit[i]) begin
                    stage_digits_reg[4*i +: 4] <= decoded[3:0];
                    stage_invalid_reg[i]       <= decoded[4];
                    stage_blank_reg[i]         <= decoded[5];
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives scan sequences and checks decoded
// frames, flags, error pulses, timeout and reset behaviour.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  invalid;
    logic        frame_valid;
    logic        scan_error;
    logic        display_off;

    int checks_cnt;
    int errors_cnt;
    int fv_cnt;
    int se_cnt;
    int fv_base;

    seg_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .anode       (anode),
        .cathode     (cathode),
        .digits      (digits),
        .blank       (blank),
        .invalid     (invalid),
        .frame_valid (frame_valid),
        .scan_error  (scan_error),
        .display_off (display_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (scan_error)  se_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] cat, input int n);
        anode   = an;
        cathode = cat;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One digit slot held 10 cycles followed by 2 blanking cycles
    task automatic scan_digit(input int pos, input logic [6:0] cat);
        logic [3:0] an;
        an = 4'hF;
        an[pos] = 1'b0;
        show(an, cat, 10);
        show(4'hF, 7'h7F, 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_digits"}, 32'(digits), 32'h0);
        check_val({tag, "_flags"}, 32'({blank, invalid}), 32'h0);
        check_val({tag, "_pulses"}, 32'({frame_valid, scan_error, display_off}), 32'h0);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        fv_cnt     = 0;
        se_cnt     = 0;
        rst        = 1'b0;
        anode      = 4'hF;
        cathode    = 7'h7F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        show(4'hF, 7'h7F, 4);

        // Nominal scan: 1 2 3 4
        scan_digit(3, 7'h79);
        scan_digit(2, 7'h24);
        scan_digit(1, 7'h30);
        scan_digit(0, 7'h19);
        show(4'hF, 7'h7F, 3);
        check_val("nom_frames", 32'(fv_cnt), 32'd1);
        check_val("nom_digits", 32'(digits), 32'h1234);
        check_val("nom_blank", 32'(blank), 32'h0);
        check_val("nom_invalid", 32'(invalid), 32'h0);

        // Blank, invalid, glitch before stable 0
        scan_digit(3, 7'h7F);
        scan_digit(2, 7'h3F);
        show(4'b1101, 7'h00, 2);
        scan_digit(1, 7'h40);
        scan_digit(0, 7'h19);
        show(4'hF, 7'h7F, 3);
        check_val("bi_frames", 32'(fv_cnt), 32'd2);
        check_val("bi_digits", 32'(digits), 32'h0004);
        check_val("bi_blank", 32'(blank), 32'b1000);
        check_val("bi_invalid", 32'(invalid), 32'b0100);

        // Overwrite of digit 0, then multi-anode
        scan_digit(0, 7'h19);
        scan_digit(0, 7'h0E);
        scan_digit(1, 7'h30);
        scan_digit(2, 7'h24);
        scan_digit(3, 7'h79);
        show(4'hF, 7'h7F, 3);
        check_val("ow_frames", 32'(fv_cnt), 32'd3);
        check_val("ow_digits", 32'(digits), 32'h123F);
        show(4'b0011, 7'h40, 10);
        show(4'hF, 7'h7F, 2);
        check_val("multi_scan_error", 32'(se_cnt), 32'd1);

        // Timeout after a partial frame
        scan_digit(3, 7'h06);
        scan_digit(2, 7'h21);
        show(4'hF, 7'h7F, 50);
        check_val("to_not_yet", 32'(display_off), 32'd0);
        show(4'hF, 7'h7F, 20);
        check_val("to_off", 32'(display_off), 32'd1);
        check_val("to_digits_held", 32'(digits), 32'h123F);
        scan_digit(1, 7'h46);
        check_val("to_on_again", 32'(display_off), 32'd0);
        scan_digit(0, 7'h03);
        show(4'hF, 7'h7F, 3);
        check_val("to_partial_dropped", 32'(fv_cnt), 32'd3);
        scan_digit(3, 7'h08);
        scan_digit(2, 7'h00);
        show(4'hF, 7'h7F, 3);
        check_val("to_frames", 32'(fv_cnt), 32'd4);
        check_val("to_digits", 32'(digits), 32'hA8CB);
        check_val("to_scan_error", 32'(se_cnt), 32'd1);

        // Reset mid-frame, then full frame scanned in 0..3 order
        scan_digit(3, 7'h79);
        scan_digit(2, 7'h24);
        scan_digit(1, 7'h30);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        #7;
        rst = 1'b1;
        fv_base = fv_cnt;
        show(4'hF, 7'h7F, 4);
        scan_digit(0, 7'h12);
        scan_digit(1, 7'h10);
        scan_digit(2, 7'h78);
        check_val("rst_no_early_frame", 32'(fv_cnt - fv_base), 32'd0);
        scan_digit(3, 7'h02);
        show(4'hF, 7'h7F, 3);
        check_val("rst_frames", 32'(fv_cnt - fv_base), 32'd1);
        check_val("rst_digits", 32'(digits), 32'h6795);
        check_val("rst_flags", 32'({blank, invalid}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
